// File: rtl/isr_sequencer.sv
// Interrupt entry/return sequencer: saves status/PC/cause, masks sources, redirects the PC.
// Optional taken-interrupt counter (isr_count) is built when ISR_COUNT_EN is defined.
module isr_sequencer #(
  parameter logic [31:0] SISR        = 32'h0000_0000,
  parameter logic [22:0] REPEAT_MASK = 23'h060000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        jisr,
  input  logic [22:0] mca,
  input  logic [4:0]  il,
  input  logic [31:0] pc_cur,
  input  logic [31:0] pc_nxt,
  input  logic        rfe,
  input  logic        sr_we,
  input  logic [31:0] sr_wdata,
  output logic [31:0] sr,
  output logic [31:0] esr,
  output logic [31:0] epc,
  output logic [22:0] eca,
  output logic        pc_load,
  output logic [31:0] pc_target,
  output logic        busy
`ifdef ISR_COUNT_EN
  ,
  output logic [15:0] isr_count
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    SAVE,
    CLEAR,
    JUMP,
    RESTORE
  } state_t;

  state_t      state;
  logic        rep;
  logic [31:0] rmask_ext;

  // Out-of-range cause indices fall back to bit 0 of the repeat mask.
  always_comb begin
    rmask_ext = {9'b0, REPEAT_MASK};
    rep       = REPEAT_MASK[0];
    if (il < 5'd23) rep = rmask_ext[il];
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      sr        <= '0;
      esr       <= '0;
      epc       <= '0;
      eca       <= '0;
      pc_load   <= 1'b0;
      pc_target <= '0;
`ifdef ISR_COUNT_EN
      isr_count <= '0;
`endif
    end else begin
      pc_load   <= 1'b0;
      pc_target <= '0;
      case (state)
        IDLE: begin
          if (jisr) begin
            state <= SAVE;
            esr   <= sr;
            eca   <= mca;
            epc   <= rep ? pc_cur : pc_nxt;
          end else if (rfe) begin
            // Restore and redirect are registered on entry so both appear in the RESTORE cycle.
            state     <= RESTORE;
            sr        <= esr;
            pc_load   <= 1'b1;
            pc_target <= epc;
          end else if (sr_we) begin
            sr <= sr_wdata;
          end
        end
        SAVE: begin
          state <= CLEAR;
          sr    <= '0;
`ifdef ISR_COUNT_EN
          if (isr_count != 16'hFFFF) isr_count <= isr_count + 16'd1;
`endif
        end
        CLEAR: begin
          state     <= JUMP;
          pc_load   <= 1'b1;
          pc_target <= SISR;
        end
        JUMP:    state <= IDLE;
        RESTORE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
